tluh_atomic_responder: RTL and testbench
========================================

TLUH_ATOMIC_RESPONDER -- requirements
Module: tluh_atomic_responder

Interface
REQ-001 Parameter SRC_W, default 8, width of TL source ID.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 a_valid_i / a_ready_o  input/output  1/1  TL-UH A-channel handshake.
REQ-005 a_opcode_i  input  3  0 PutFullData, 1 PutPartialData, 2 ArithmeticData, 3 LogicalData, 4 Get.
REQ-006 a_param_i  input  3  LogicalData op: 0 XOR, 1 OR, 2 AND, 3 SWAP.
REQ-007 a_size_i  input  2  log2 bytes, echoed on D.
REQ-008 a_source_i  input  SRC_W  requester ID, echoed on D.
REQ-009 a_address_i  input  32  byte address; word index = a_address_i[31:2].
REQ-010 a_mask_i  input  4  byte lanes.
REQ-011 a_data_i  input  32  write/operand data.
REQ-012 d_valid_o / d_ready_i  output/input  1/1  D-channel handshake.
REQ-013 d_opcode_o  output  3  0 AccessAck, 1 AccessAckData.
REQ-014 d_size_o, d_source_o, d_data_o, d_error_o  output  2, SRC_W, 32, 1  D response fields.
REQ-015 mem_req_o / mem_gnt_i  output/input  1/1  memory request handshake.
REQ-016 mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o  output  1, 30, 4, 32  memory request fields (word address).
REQ-017 mem_rvalid_i, mem_rdata_i  input  1, 32  read return, >=1 cycle after read grant.

Function
REQ-018 FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP; a_ready_o=1 only in IDLE; one transaction outstanding.
REQ-019 IDLE, a_valid_i&a_ready_o: latch all A fields; Get/LogicalData -> RD_REQ; Put* -> WR_REQ; ArithmeticData or other opcode -> RESP with d_error_o=1, d_opcode_o=1, d_data_o=0, no memory access.
REQ-020 RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=latched addr[31:2]; held stable until mem_gnt_i; then RD_WAIT.
REQ-021 RD_WAIT: on mem_rvalid_i capture old=mem_rdata_i; Get -> RESP; LogicalData -> WR_REQ.
REQ-022 LogicalData new value per lane: XOR old^data, OR old|data, AND old&data, SWAP data; lanes with mask bit 0 keep old; param 4-7 -> RESP with d_error_o=1, no write.
REQ-023 WR_REQ: mem_req_o=1, mem_we_o=1; Put: wdata=a_data, wmask=a_mask (PutFull forces 4'hF); Logical: wdata=new, wmask=4'hF; held until mem_gnt_i, then RESP; write complete on grant.
REQ-024 RESP: d_valid_o=1, fields stable until d_ready_i; Put -> opcode 0, data 0; Get/Logical -> opcode 1, data=old; d_size_o/d_source_o=latched; on d_ready_i -> IDLE.
REQ-025 Minimum latency Logical, gnt and rvalid immediate: accept cycle N, read req N+1, rvalid N+2, write req N+3, d_valid N+4.
REQ-026 mem_rvalid_i outside RD_WAIT ignored; d_ready_i outside RESP ignored.
REQ-027 Back-to-back: d handshake cycle returns to IDLE; next A accepted at earliest the following cycle.

Reset
REQ-028 rst_i asserted: state IDLE, a_ready_o=0 during reset then 1 in first cycle after release; d_valid_o=0, mem_req_o=0, mem_we_o=0; all latched fields and d_* data 0.
REQ-029 Reset mid-transaction aborts it with no response; a write already granted is not rolled back.

Verification
REQ-030 mem[0x10]=0x0F0F_0F0F; LogicalData XOR addr 0x40 mask F data 0xFFFF_0000 src 5 -> D opcode 1, data 0x0F0F_0F0F, source 5; mem=0xF0F0_0F0F.
REQ-031 mem[1]=0x1234_5678; LogicalData AND mask 4'b0011 data 0 addr 0x4 -> D data 0x1234_5678; mem=0x1234_0000.
REQ-032 PutPartialData addr 0x8 mask 4'b1000 data 0xAB00_0000 -> write wmask 1000; D opcode 0, error 0; Get addr 0x8 returns byte3=0xAB.
REQ-033 ArithmeticData any -> D error 1, opcode 1, data 0; mem_req_o never asserted.
REQ-034 SWAP with gnt delayed 3 cycles and d_ready_i low 5 cycles -> mem fields and D fields stable throughout; a_ready_o=0 until D handshake.
REQ-035 rst_i pulsed during RD_WAIT -> d_valid_o=0, a_ready_o=1 after release; late mem_rvalid_i ignored.

Source files
------------

// File: rtl/tluh_atomic_responder.sv
// rtl/tluh_atomic_responder.sv - TL-UH slave with Get/Put/LogicalData atomics over a word memory port
module tluh_atomic_responder #(
    parameter int SRC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [2:0]       a_opcode_i,
    input  logic [2:0]       a_param_i,
    input  logic [1:0]       a_size_i,
    input  logic [SRC_W-1:0] a_source_i,
    input  logic [31:0]      a_address_i,
    input  logic [3:0]       a_mask_i,
    input  logic [31:0]      a_data_i,
    output logic             d_valid_o,
    input  logic             d_ready_i,
    output logic [2:0]       d_opcode_o,
    output logic [1:0]       d_size_o,
    output logic [SRC_W-1:0] d_source_o,
    output logic [31:0]      d_data_o,
    output logic             d_error_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic             mem_we_o,
    output logic [29:0]      mem_addr_o,
    output logic [3:0]       mem_wmask_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_LOGICAL  = 3'd3;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       op_q;
    logic [2:0]       param_q;
    logic [1:0]       size_q;
    logic [SRC_W-1:0] source_q;
    logic [29:0]      addr_q;
    logic [3:0]       mask_q;
    logic [31:0]      data_q;
    logic [3:0]       wmask_q;
    logic [31:0]      wdata_q;
    logic             d_opcode_q;
    logic [31:0]      d_data_q;
    logic             d_error_q;

    logic [31:0]      logic_res;
    logic [31:0]      merged_word;
    logic             accept;
    logic             is_put;
    logic             a_known;
    logic             bad_param;

    // The byte offset within the word plays no part in a word-wide access.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^a_address_i[1:0];

    assign accept    = (state_q == IDLE) && a_valid_i;
    assign is_put    = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
    assign a_known   = is_put || (a_opcode_i == OP_GET) || (a_opcode_i == OP_LOGICAL);
    assign bad_param = (op_q == OP_LOGICAL) && param_q[2];

    // Atomic result: apply the logical op word-wide, then keep old bytes on unmasked lanes.
    always_comb begin
        logic_res   = data_q;
        merged_word = mem_rdata_i;
        case (param_q[1:0])
            2'd0:    logic_res = mem_rdata_i ^ data_q;
            2'd1:    logic_res = mem_rdata_i | data_q;
            2'd2:    logic_res = mem_rdata_i & data_q;
            default: logic_res = data_q;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) begin
                merged_word[8*i +: 8] = logic_res[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_ready_o = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        d_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                a_ready_o = !rst_i;
                if (a_valid_i) begin
                    if (is_put) begin
                        state_d = WR_REQ;
                    end else if (a_known) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RD_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    if ((op_q == OP_LOGICAL) && !param_q[2]) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WR_REQ: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                d_valid_o = 1'b1;
                if (d_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the request on accept and build the write/response payload as the transaction advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            param_q    <= '0;
            size_q     <= '0;
            source_q   <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            d_opcode_q <= 1'b0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= a_opcode_i;
            param_q    <= a_param_i;
            size_q     <= a_size_i;
            source_q   <= a_source_i;
            addr_q     <= a_address_i[31:2];
            mask_q     <= a_mask_i;
            data_q     <= a_data_i;
            wmask_q    <= (a_opcode_i == OP_PUT_FULL) ? 4'hF : a_mask_i;
            wdata_q    <= a_data_i;
            d_opcode_q <= !is_put;
            d_data_q   <= '0;
            d_error_q  <= !a_known;
        end else if ((state_q == RD_WAIT) && mem_rvalid_i) begin
            d_data_q  <= bad_param ? 32'h0 : mem_rdata_i;
            d_error_q <= bad_param;
            if (op_q == OP_LOGICAL) begin
                wdata_q <= merged_word;
                wmask_q <= 4'hF;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wmask_o = wmask_q;
    assign mem_wdata_o = wdata_q;
    assign d_opcode_o  = {2'b00, d_opcode_q};
    assign d_size_o    = size_q;
    assign d_source_o  = source_q;
    assign d_data_o    = d_data_q;
    assign d_error_o   = d_error_q;

endmodule

// File: tb/tb_tluh_atomic_responder.sv
// tb/tb_tluh_atomic_responder.sv - randomized and directed bench for tluh_atomic_responder
module tb_tluh_atomic_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_rdata;

    int ncomp = 0;
    int nfail = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    int gnt_delay = 0, rv_delay = 0, gnt_cnt = 0, rv_cnt = 0;
    bit rd_sched = 0;
    int rd_idx = 0;
    int req_count = 0;
    logic [3:0] last_wmask = 4'h0;

    bit in_req = 0, in_resp = 0, mem_unstable = 0, d_unstable = 0;
    logic [66:0] req_snap;
    logic [44:0] resp_snap;

    tluh_atomic_responder #(.SRC_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_param_i(a_param),
        .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask),
        .a_data_i(a_data),
        .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_size_o(d_size),
        .d_source_o(d_source), .d_data_o(d_data), .d_error_o(d_error),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory agent: grants after gnt_delay cycles of request, returns reads rv_delay cycles after the grant cycle.
    always @(negedge clk) begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (rd_sched) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem[rd_idx];
                rd_sched = 0;
            end else begin
                rv_cnt--;
            end
        end
        if (mem_req) begin
            if (gnt_cnt >= gnt_delay) begin
                mem_gnt = 1'b1;
                gnt_cnt = 0;
                req_count++;
                if (mem_we) begin
                    last_wmask = mem_wmask;
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask[b]) mem[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    rd_sched = 1;
                    rd_idx = int'(mem_addr[5:0]);
                    rv_cnt = rv_delay;
                end
            end else begin
                gnt_cnt++;
            end
        end else begin
            gnt_cnt = 0;
        end
    end

    // Stability watch: request and response fields must not move while waiting for the other side.
    always @(negedge clk) begin
        if (mem_req) begin
            if (in_req && req_snap !== {mem_we, mem_addr, mem_wmask, mem_wdata}) mem_unstable = 1;
            req_snap = {mem_we, mem_addr, mem_wmask, mem_wdata};
            in_req = 1;
        end else begin
            in_req = 0;
        end
        if (d_valid) begin
            if (in_resp && resp_snap !== {d_opcode, d_size, d_source, d_data, d_error}) d_unstable = 1;
            resp_snap = {d_opcode, d_size, d_source, d_data, d_error};
            in_resp = 1;
        end else begin
            in_resp = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] logic_op(input logic [2:0] p, input logic [31:0] o, input logic [31:0] d);
        case (p)
            3'd0: return o ^ d;
            3'd1: return o | d;
            3'd2: return o & d;
            default: return d;
        endcase
    endfunction

    task automatic wait_ready();
        for (int c = 0; c < 50 && !a_ready; c++) @(negedge clk);
        check("a_ready_before_issue", {31'b0, a_ready}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] prm, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                         input logic [1:0] sz);
        a_valid = 1; a_opcode = op; a_param = prm; a_address = addr;
        a_mask = mask; a_data = data; a_source = src; a_size = sz;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0; a_opcode = 3'd7; a_param = 3'd7; a_address = '1; a_mask = '0; a_data = '1;
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [2:0] prm, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                           input logic [1:0] sz, input int gd, input int rd, input int dd,
                           input bit chk_lat, output logic [31:0] got_data);
        int idx, exp_reqs, req0, lat;
        logic [31:0] old, exp_data;
        logic exp_err, exp_op, got, aready_bad;
        logic [3:0] exp_wmask;
        idx = int'(addr[7:2]);
        old = ref_mem[idx];
        exp_err = 0; exp_data = 0; exp_op = 1; exp_reqs = 0; exp_wmask = 0;
        case (op)
            3'd0: begin exp_op = 0; exp_reqs = 1; exp_wmask = 4'hF; ref_mem[idx] = data; end
            3'd1: begin exp_op = 0; exp_reqs = 1; exp_wmask = mask; ref_mem[idx] = merge(old, data, mask); end
            3'd4: begin exp_data = old; exp_reqs = 1; end
            3'd3: begin
                if (prm < 3'd4) begin
                    exp_data = old; exp_reqs = 2; exp_wmask = 4'hF;
                    ref_mem[idx] = merge(old, logic_op(prm, old, data), mask);
                end else begin
                    exp_err = 1; exp_reqs = 1;
                end
            end
            default: exp_err = 1;
        endcase

        gnt_delay = gd; rv_delay = rd;
        wait_ready();
        req0 = req_count; mem_unstable = 0; d_unstable = 0;
        issue(op, prm, addr, mask, data, src, sz);
        got = 0; aready_bad = 0; lat = 0;
        for (int c = 1; c <= 100; c++) begin
            if (d_valid) begin got = 1; lat = c; break; end
            if (a_ready) aready_bad = 1;
            @(negedge clk);
        end
        check("d_valid_seen", {31'b0, got}, 32'd1);
        got_data = d_data;
        check("d_opcode", {29'b0, d_opcode}, {31'b0, exp_op});
        check("d_data", d_data, exp_data);
        check("d_error", {31'b0, d_error}, {31'b0, exp_err});
        check("d_source", {24'b0, d_source}, {24'b0, src});
        check("d_size", {30'b0, d_size}, {30'b0, sz});
        if (chk_lat) check("latency", lat, 4);
        for (int c = 0; c < dd; c++) begin
            @(negedge clk);
            if (a_ready || !d_valid) aready_bad = 1;
        end
        d_ready = 1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 0;
        check("a_ready_held_low", {31'b0, aready_bad}, 32'd0);
        check("idle_after_d", {30'b0, a_ready, d_valid}, 32'd2);
        check("mem_req_count", req_count - req0, exp_reqs);
        if (exp_wmask != 4'h0) check("write_mask", {28'b0, last_wmask}, {28'b0, exp_wmask});
        check("mem_word", mem[idx], ref_mem[idx]);
        check("mem_fields_stable", {31'b0, mem_unstable}, 32'd0);
        check("d_fields_stable", {31'b0, d_unstable}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        logic [2:0] op, prm;
        int r, req0;
        bit bad;
        rst = 1; a_valid = 0; d_ready = 0; a_opcode = 0; a_param = 0; a_size = 0;
        a_source = 0; a_address = 0; a_mask = 0; a_data = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'h0F0F_0F0F; ref_mem[16] = 32'h0F0F_0F0F;
        mem[1]  = 32'h1234_5678; ref_mem[1]  = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check("rst_a_ready", {31'b0, a_ready}, 32'd0);
        check("rst_d_valid", {31'b0, d_valid}, 32'd0);
        check("rst_mem_req_we", {30'b0, mem_req, mem_we}, 32'd0);
        check("rst_d_data", d_data, 32'd0);
        check("rst_d_fields", {21'b0, d_opcode, d_size, d_source, d_error}, 32'd0);
        rst = 0;
        @(negedge clk);
        check("a_ready_after_rst", {31'b0, a_ready}, 32'd1);

        run_txn(3'd3, 3'd0, 32'h40, 4'hF, 32'hFFFF_0000, 8'd5, 2'd2, 0, 0, 0, 1, rdata);
        check("xor_mem_value", mem[16], 32'hF0F0_0F0F);
        run_txn(3'd3, 3'd2, 32'h4, 4'b0011, 32'h0, 8'd9, 2'd2, 0, 0, 0, 1, rdata);
        check("and_old_data", rdata, 32'h1234_5678);
        check("and_mem_value", mem[1], 32'h1234_0000);
        run_txn(3'd1, 3'd0, 32'h8, 4'b1000, 32'hAB00_0000, 8'd3, 2'd0, 1, 0, 1, 0, rdata);
        run_txn(3'd4, 3'd0, 32'h8, 4'hF, 32'h0, 8'd4, 2'd2, 0, 1, 0, 0, rdata);
        check("partial_byte3", {24'b0, rdata[31:24]}, 32'hAB);
        run_txn(3'd2, 3'd1, 32'hC, 4'hF, 32'h5555_5555, 8'd7, 2'd2, 0, 0, 2, 0, rdata);
        run_txn(3'd3, 3'd3, 32'h14, 4'b0110, 32'hCAFE_BABE, 8'hA5, 2'd1, 3, 2, 5, 0, rdata);
        run_txn(3'd3, 3'd5, 32'h18, 4'hF, 32'h1111_2222, 8'd1, 2'd2, 1, 0, 0, 0, rdata);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    op = 3'd0;
                2, 3:    op = 3'd1;
                4, 5:    op = 3'd4;
                6, 7, 8: op = 3'd3;
                default: op = 3'($urandom_range(5, 7));
            endcase
            prm = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            run_txn(op, prm, {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                    4'($urandom), $urandom, 8'($urandom), 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 0, rdata);
        end

        // Reset while the read is outstanding: no response, no write, late read data ignored.
        gnt_delay = 0; rv_delay = 3;
        wait_ready();
        req0 = req_count;
        issue(3'd3, 3'd0, 32'h20, 4'hF, 32'hFFFF_FFFF, 8'd2, 2'd2);
        for (int c = 0; c < 20 && !mem_gnt; c++) @(negedge clk);
        check("abort_read_granted", {31'b0, mem_gnt}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check("abort_rst_outputs", {29'b0, a_ready, d_valid, mem_req}, 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (d_valid || !a_ready || mem_req) bad = 1;
            @(negedge clk);
        end
        check("abort_idle_quiet", {31'b0, bad}, 32'd0);
        check("abort_req_count", req_count - req0, 1);
        check("abort_mem_unchanged", mem[8], ref_mem[8]);
        run_txn(3'd4, 3'd0, 32'h20, 4'hF, 32'h0, 8'd6, 2'd2, 0, 0, 0, 0, rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
